ram_bist_ctrl: RTL and testbench
================================

Name: ram_bist_ctrl

Overview:
Built-in self-test initiator for the team's 64x8 single-port RAM, which has a registered read address. The controller drives the RAM's data/addr/we inputs and checks its q output. It runs a 4-element March sequence (W, R/W, R/W, R), then reports pass/fail, plus the first failing address and the data read there. It sits between the top-level test/config logic and the RAM instance, and owns the RAM's inputs while busy.

Parameters:
ADDR_W, 6, RAM address width; depth = 2**ADDR_W.
DATA_W, 8, RAM data width.
BG, 8'h55, background pattern; ~BG is the complement pattern.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  one-cycle request to begin a test run; sampled in IDLE and DONE only.
mem_data  output  DATA_W  write data to RAM data port.
mem_addr  output  ADDR_W  address to RAM addr port.
mem_we  output  1  RAM write enable.
mem_q  input  DATA_W  RAM read data; valid the cycle after an address is presented with mem_we=0.
busy  output  1  high from the first March cycle through the last check cycle.
done  output  1  level; high while in DONE.
pass  output  1  valid when done=1; 1 = no mismatch.
fail_addr  output  ADDR_W  address of the first mismatch; 0 if none.
fail_data  output  DATA_W  mem_q value captured at the first mismatch; 0 if none.

Behaviour:
- Reset (rst=1 at an edge): next cycle state=IDLE, addr counter=0; all outputs 0 (mem_we=0, mem_addr=0, mem_data=0, busy=done=pass=0, fail_*=0). Reset mid-run aborts immediately; no further RAM writes.
- mem_* outputs are decoded from the state register and address counter. In IDLE and DONE, mem_we=0.
- States: IDLE, M0_WR, M1_RD, M1_CHK, M2_RD, M2_CHK, M3_RD, M3_CHK, DONE.
- IDLE, start=1 -> M0_WR, addr=0. Clears pass and fail_*.
- M0_WR (ascending): mem_we=1, mem_data=BG. addr increments each cycle; at addr=max -> M1_RD, addr=0.
- Mx_RD: mem_we=0, mem_addr=addr. This loads the RAM's address register. -> Mx_CHK.
- Mx_CHK: mem_addr held. Compare mem_q against expected: M1 expects BG, M2 expects ~BG, M3 expects BG.
  - M1_CHK writes ~BG (mem_we=1) in the same cycle.
  - M2_CHK writes BG (mem_we=1) in the same cycle.
  - M3_CHK: mem_we=0.
  - mem_q is sampled at the same edge as the write, so the compare sees the pre-write value.
- Order: M1 ascending (0..max). M2 and M3 descending (max..0), with addr loaded to max on entry. At the element end address, go to the next element's RD; after M3 -> DONE.
- Mismatch (default build): latch fail_addr=addr and fail_data=mem_q; next state DONE with pass=0. The write in that CHK cycle still occurs.
- No mismatch at end of M3: DONE with pass=1.
- Cycle count for a clean run (depth 64): 64 + 3*128 = 448 busy cycles. done=1 in cycle 449, counting the first M0_WR cycle as cycle 1.
- DONE: outputs held. start=1 -> M0_WR (restart); done deasserts and pass/fail_* clear in the same cycle.
- start while busy: ignored. rst has priority over start.

Optional Feature:
Macro RAM_BIST_ERRCNT_EN.
- Defined: adds output err_cnt (8 bits, saturates at 255, cleared on rst and on start). A mismatch increments err_cnt, and the run continues to the end of M3. fail_addr/fail_data still hold the first mismatch. pass = (err_cnt==0). done always rises at cycle 449.
- Undefined: no err_cnt port; the run stops on the first mismatch as above.

Test Plan:
- Fault-free RAM model, start pulse -> busy for exactly 448 cycles; done=1 in cycle 449; pass=1; fail_addr=0; fail_data=0. Final RAM contents all 8'h55.
- RAM model with bit3 of addr 0x2A stuck-at-1 -> M1_CHK at cycle 150 reads 8'h5D. done=1 in cycle 151, pass=0, fail_addr=6'h2A, fail_data=8'h5D.
- Bit0 of addr 0x3F stuck-at-0 -> first mismatch in M1, fail_addr=6'h3F, fail_data=8'h54.
- Second start pulse at cycle 100 of a run -> ignored; done still at cycle 449. start in DONE -> done=0 next cycle, and a full 448-cycle run repeats.
- rst=1 at cycle 200 -> next cycle all outputs 0 and state IDLE; no mem_we pulse after the reset edge. A later start runs cleanly.
- With RAM_BIST_ERRCNT_EN, addr 0x2A bit3 stuck-at-1 -> errors in M1, M2 (reads 8'hAA|0x08 = 8'hAA? no: ~BG=8'hAA has bit3=1, so no M2 error) and M3. Result: err_cnt=2, pass=0, fail_addr=6'h2A, done at cycle 449.

Source files
------------

// File: rtl/ram_bist_ctrl.sv
// March-test BIST controller (W / R-W / R-W / R) for a single-port RAM with a registered read address.
// Optional macro RAM_BIST_ERRCNT_EN: count every mismatch in err_cnt and always run through the last element.
module ram_bist_ctrl #(
    parameter int                ADDR_W = 6,
    parameter int                DATA_W = 8,
    parameter logic [DATA_W-1:0] BG     = 8'h55
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [DATA_W-1:0] mem_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_q,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data
`ifdef RAM_BIST_ERRCNT_EN
    ,
    output logic [7:0]        err_cnt
`endif
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_M0_WR,
        S_M1_RD,
        S_M1_CHK,
        S_M2_RD,
        S_M2_CHK,
        S_M3_RD,
        S_M3_CHK,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [DATA_W-1:0]   w_expect;
    logic                w_chk;
    logic                w_mismatch;
    logic                w_go;
    logic                r_pass;
    logic                r_fail_seen;
    logic [ADDR_W-1:0]   r_fail_addr;
    logic [DATA_W-1:0]   r_fail_data;
`ifdef RAM_BIST_ERRCNT_EN
    logic [7:0]          r_err_cnt;
`endif

    assign w_go = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
        end
    end

    // RAM port decode and sequencing; each CHK cycle both compares the old word and writes the new one.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        mem_we      = 1'b0;
        mem_data    = '0;
        mem_addr    = '0;
        w_expect    = BG;
        w_chk       = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt = S_M0_WR;
                    w_addr_nxt  = '0;
                end
            end
            S_M0_WR: begin
                mem_we   = 1'b1;
                mem_data = BG;
                mem_addr = r_addr;
                if (r_addr == ADDR_MAX) begin
                    w_state_nxt = S_M1_RD;
                    w_addr_nxt  = '0;
                end else begin
                    w_addr_nxt  = r_addr + 1'b1;
                end
            end
            S_M1_RD: begin
                mem_addr    = r_addr;
                w_state_nxt = S_M1_CHK;
            end
            S_M1_CHK: begin
                mem_addr = r_addr;
                mem_we   = 1'b1;
                mem_data = ~BG;
                w_chk    = 1'b1;
                w_expect = BG;
                if (r_addr == ADDR_MAX) begin
                    w_state_nxt = S_M2_RD;
                    w_addr_nxt  = ADDR_MAX;
                end else begin
                    w_state_nxt = S_M1_RD;
                    w_addr_nxt  = r_addr + 1'b1;
                end
            end
            S_M2_RD: begin
                mem_addr    = r_addr;
                w_state_nxt = S_M2_CHK;
            end
            S_M2_CHK: begin
                mem_addr = r_addr;
                mem_we   = 1'b1;
                mem_data = BG;
                w_chk    = 1'b1;
                w_expect = ~BG;
                if (r_addr == '0) begin
                    w_state_nxt = S_M3_RD;
                    w_addr_nxt  = ADDR_MAX;
                end else begin
                    w_state_nxt = S_M2_RD;
                    w_addr_nxt  = r_addr - 1'b1;
                end
            end
            S_M3_RD: begin
                mem_addr    = r_addr;
                w_state_nxt = S_M3_CHK;
            end
            S_M3_CHK: begin
                mem_addr = r_addr;
                w_chk    = 1'b1;
                w_expect = BG;
                if (r_addr == '0) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_M3_RD;
                    w_addr_nxt  = r_addr - 1'b1;
                end
            end
            S_DONE: begin
                busy = 1'b0;
                done = 1'b1;
                if (start) begin
                    w_state_nxt = S_M0_WR;
                    w_addr_nxt  = '0;
                end
            end
            default: begin
                busy        = 1'b0;
                w_state_nxt = S_IDLE;
                w_addr_nxt  = '0;
            end
        endcase
        w_mismatch = w_chk && (mem_q != w_expect);
`ifndef RAM_BIST_ERRCNT_EN
        if (w_mismatch) begin
            w_state_nxt = S_DONE;
        end
`endif
    end

    // Result registers: first mismatch is kept, later ones only bump the counter.
    always_ff @(posedge clk) begin
        if (rst || w_go) begin
            r_pass      <= 1'b0;
            r_fail_seen <= 1'b0;
            r_fail_addr <= '0;
            r_fail_data <= '0;
        end else begin
            if (w_mismatch && !r_fail_seen) begin
                r_fail_seen <= 1'b1;
                r_fail_addr <= r_addr;
                r_fail_data <= mem_q;
            end
            if ((r_state == S_M3_CHK) && (r_addr == '0)) begin
                r_pass <= !(w_mismatch || r_fail_seen);
            end
        end
    end

`ifdef RAM_BIST_ERRCNT_EN
    always_ff @(posedge clk) begin
        if (rst || w_go) begin
            r_err_cnt <= '0;
        end else if (w_mismatch && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

    assign pass      = r_pass;
    assign fail_addr = r_fail_addr;
    assign fail_data = r_fail_data;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: RAM model with an injectable stuck-at bit, directed table, corner sequences
// and random faults checked against a March-level reference model.
`timescale 1ns/1ps
module tb_ram_bist_ctrl;
    localparam int           AW = 6;
    localparam int           DW = 8;
    localparam logic [7:0]   BG = 8'h55;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] mem_data;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_q;
    logic          busy;
    logic          done;
    logic          pass;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_data;
`ifdef RAM_BIST_ERRCNT_EN
    logic [7:0]    err_cnt;
`endif

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    ram_bist_ctrl #(.ADDR_W(AW), .DATA_W(DW), .BG(BG)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mem_data  (mem_data),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_q     (mem_q),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_addr (fail_addr),
        .fail_data (fail_data)
`ifdef RAM_BIST_ERRCNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    // RAM with registered read address; the fault forces one bit of one word on the read path.
    logic [DW-1:0] ram [64];
    logic [AW-1:0] ram_ra;
    logic          f_en;
    logic [AW-1:0] f_addr;
    int            f_bit;
    logic          f_val;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_data;
        ram_ra <= mem_addr;
    end

    always_comb begin
        mem_q = ram[ram_ra];
        if (f_en && (ram_ra == f_addr)) mem_q[f_bit] = f_val;
    end

    typedef struct {
        logic       fe;
        logic [5:0] fa;
        int         fb;
        logic       fv;
        int         cyc;
        logic       ps;
        logic [5:0] faddr;
        logic [7:0] fdata;
        int         ecnt;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: walk the March elements over an array, applying the fault to every read.
    task automatic model(input logic fe, input logic [5:0] fa, input int fb, input logic fv,
                         output int cyc, output logic ps, output logic [5:0] faddr,
                         output logic [7:0] fdata, output int ecnt);
        logic [7:0] m [64];
        logic [7:0] rd, expv, wv;
        int t, first_t, a;
        ecnt = 0; first_t = 0; faddr = '0; fdata = '0;
        for (int i = 0; i < 64; i++) m[i] = BG;
        t = 64;
        for (int e = 1; e <= 3; e++) begin
            expv = (e == 2) ? ~BG : BG;
            wv   = (e == 1) ? ~BG : BG;
            for (int k = 0; k < 64; k++) begin
                a = (e == 1) ? k : 63 - k;
                t += 2;
                rd = m[a];
                if (fe && (a == int'(fa))) rd[fb] = fv;
                if (rd != expv) begin
                    if (ecnt == 0) begin
                        faddr = a[5:0];
                        fdata = rd;
                        first_t = t;
                    end
                    if (ecnt < 255) ecnt++;
                end
                if (e != 3) m[a] = wv;
            end
        end
        ps = (ecnt == 0);
`ifdef RAM_BIST_ERRCNT_EN
        cyc = t + 1;
`else
        cyc = (ecnt == 0) ? t + 1 : first_t + 1;
`endif
    endtask

    // Pulse start, optionally re-pulse at cycle sa or reset at cycle ra; cycle 1 is the first run cycle.
    task automatic run(input int sa, input int ra, output int cyc, output int bcnt);
        int n;
        bit fin;
        n = 0; bcnt = 0; cyc = 0; fin = 0;
        start = 1'b1;
        while (!fin) begin
            @(negedge clk);
            n++;
            start = (n == sa);
            if (busy) bcnt++;
            if (n == 1)
                chk("first_cycle_clear", {done, busy, pass, fail_addr, fail_data},
                    {1'b0, 1'b1, 1'b0, 6'h00, 8'h00});
            if ((ra != 0) && (n == ra)) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("rst_outputs_zero",
                    {mem_we, mem_addr, mem_data, busy, done, pass, fail_addr, fail_data}, 32'h0);
`ifdef RAM_BIST_ERRCNT_EN
                chk("rst_err_cnt", err_cnt, 0);
`endif
                cyc = n;
                fin = 1;
            end else if (done) begin
                chk("done_no_we", mem_we, 0);
                cyc = n;
                fin = 1;
            end else if (n >= 1000) begin
                n_checks++;
                n_err++;
                $display("FAIL run_timeout: got no done after %0d cycles, expected done", n);
                cyc = n;
                fin = 1;
            end
        end
    endtask

    initial begin
        int cyc, bcnt, bad, wecnt;
        int m_cyc, m_ecnt;
        logic m_ps;
        logic [5:0] m_fa;
        logic [7:0] m_fd;

        rst = 1'b1; start = 1'b0;
        f_en = 1'b0; f_addr = '0; f_bit = 0; f_val = 1'b0;

`ifdef RAM_BIST_ERRCNT_EN
        vecs[0] = '{1'b0, 6'h00, 0, 1'b0, 449, 1'b1, 6'h00, 8'h00, 0};
        vecs[1] = '{1'b1, 6'h2A, 3, 1'b1, 449, 1'b0, 6'h2A, 8'h5D, 2};
        vecs[2] = '{1'b1, 6'h3F, 0, 1'b0, 449, 1'b0, 6'h3F, 8'h54, 2};
        vecs[3] = '{1'b1, 6'h00, 7, 1'b0, 449, 1'b0, 6'h00, 8'h2A, 1};
`else
        vecs[0] = '{1'b0, 6'h00, 0, 1'b0, 449, 1'b1, 6'h00, 8'h00, 0};
        vecs[1] = '{1'b1, 6'h2A, 3, 1'b1, 151, 1'b0, 6'h2A, 8'h5D, 1};
        vecs[2] = '{1'b1, 6'h3F, 0, 1'b0, 193, 1'b0, 6'h3F, 8'h54, 1};
        vecs[3] = '{1'b1, 6'h00, 7, 1'b0, 321, 1'b0, 6'h00, 8'h2A, 1};
`endif

        repeat (2) @(negedge clk);
        chk("reset_state",
            {mem_we, mem_addr, mem_data, busy, done, pass, fail_addr, fail_data}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            f_en = vecs[i].fe; f_addr = vecs[i].fa; f_bit = vecs[i].fb; f_val = vecs[i].fv;
            run(0, 0, cyc, bcnt);
            chk("vec_done_cycle", cyc, vecs[i].cyc);
            chk("vec_busy_cycles", bcnt, vecs[i].cyc - 1);
            chk("vec_pass", pass, vecs[i].ps);
            chk("vec_fail_addr", fail_addr, vecs[i].faddr);
            chk("vec_fail_data", fail_data, vecs[i].fdata);
`ifdef RAM_BIST_ERRCNT_EN
            chk("vec_err_cnt", err_cnt, vecs[i].ecnt);
`endif
            if (!vecs[i].fe) begin
                bad = 0;
                for (int a = 0; a < 64; a++) if (ram[a] !== BG) bad++;
                chk("final_ram_bad_words", bad, 0);
            end
        end

        // Stray start while busy, then hold in DONE.
        f_en = 1'b0;
        run(100, 0, cyc, bcnt);
        chk("start_busy_done_cycle", cyc, 449);
        chk("start_busy_cycles", bcnt, 448);
        chk("start_busy_pass", pass, 1);
        repeat (5) @(negedge clk);
        chk("done_held", {done, busy, pass, mem_we}, 4'b1010);

        // Reset in the middle of a run, then a clean run.
        run(0, 200, cyc, bcnt);
        wecnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (mem_we || busy || done) wecnt++;
        end
        chk("post_rst_idle_activity", wecnt, 0);
        run(0, 0, cyc, bcnt);
        chk("post_rst_done_cycle", cyc, 449);
        chk("post_rst_pass", pass, 1);

        // Random faults against the reference model.
        for (int r = 0; r < 8; r++) begin
            f_en   = ($urandom_range(0, 3) != 0);
            f_addr = 6'($urandom_range(0, 63));
            f_bit  = int'($urandom_range(0, 7));
            f_val  = 1'($urandom_range(0, 1));
            model(f_en, f_addr, f_bit, f_val, m_cyc, m_ps, m_fa, m_fd, m_ecnt);
            run(0, 0, cyc, bcnt);
            chk("rnd_done_cycle", cyc, m_cyc);
            chk("rnd_pass", pass, m_ps);
            chk("rnd_fail_addr", fail_addr, m_fa);
            chk("rnd_fail_data", fail_data, m_fd);
`ifdef RAM_BIST_ERRCNT_EN
            chk("rnd_err_cnt", err_cnt, m_ecnt);
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
